// File: rtl/top_input_loader.sv
// ---------------------------------------------------------------------------
// top_input_loader
//
// Byte-serial front end of the Top pipeline. A contiguous i_start burst of
// 16 salt bytes followed by PW_LEN password bytes is assembled into parallel
// key material for the key-derivation core. After i_key_done, a second burst
// of 16 bytes is assembled into a message block for the cipher core. o_ien
// is the host-visible busy flag: its falling edge after the key handshake
// tells the host that message bytes may be sent.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst_n        synchronous active-low reset
//   i_data       input byte, sampled while i_start=1
//   i_start      byte-valid strobe, held high for a whole burst
//   i_key_done   one-cycle pulse: salt/password consumed
//   i_msg_ack    one-cycle pulse: message consumed
//   o_salt       assembled salt, first byte in [127:120]
//   o_pw         assembled password, first byte in the MSB byte
//   o_key_valid  level: o_salt/o_pw complete and stable
//   o_msg        assembled message, first byte in [127:120]
//   o_msg_valid  level: o_msg complete and stable
//   o_ien        busy/running flag
//   o_err        one-cycle pulse on a truncated burst
// ---------------------------------------------------------------------------
module top_input_loader #(
    parameter int PW_LEN   = 15,
    parameter int SALT_LEN = 16,
    parameter int MSG_LEN  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          i_data,
    input  logic                i_start,
    input  logic                i_key_done,
    input  logic                i_msg_ack,
    output logic [127:0]        o_salt,
    output logic [PW_LEN*8-1:0] o_pw,
    output logic                o_key_valid,
    output logic [127:0]        o_msg,
    output logic                o_msg_valid,
    output logic                o_ien,
    output logic                o_err
);

    localparam int PW_W    = PW_LEN * 8;
    localparam int KEY_LEN = SALT_LEN + PW_LEN;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        WAIT_KEY,
        WAIT_MSG,
        LOAD_MSG,
        HOLD_MSG,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [127:0]   salt_q, salt_d;
    logic [PW_W-1:0] pw_q, pw_d;
    logic [127:0]   msg_q, msg_d;
    logic           key_valid_q, key_valid_d;
    logic           msg_valid_q, msg_valid_d;
    logic           ien_q, ien_d;
    logic           err_q, err_d;

    // Byte counter holds at its maximum instead of wrapping.
    function automatic logic [5:0] sat_inc(input logic [5:0] v);
        return (v == 6'h3F) ? v : v + 6'd1;
    endfunction

    // Shift-based assembly: the first byte ends up in the MSB byte once the
    // field is full. A shift works for any PW_LEN, including 1.
    function automatic logic [PW_W-1:0] pw_shift(input logic [PW_W-1:0] v,
                                                 input logic [7:0]      b);
        return (v << 8) | PW_W'(b);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            salt_q      <= '0;
            pw_q        <= '0;
            msg_q       <= '0;
            key_valid_q <= 1'b0;
            msg_valid_q <= 1'b0;
            ien_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            salt_q      <= salt_d;
            pw_q        <= pw_d;
            msg_q       <= msg_d;
            key_valid_q <= key_valid_d;
            msg_valid_q <= msg_valid_d;
            ien_q       <= ien_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        salt_d      = salt_q;
        pw_d        = pw_q;
        msg_d       = msg_q;
        key_valid_d = key_valid_q;
        msg_valid_d = msg_valid_q;
        ien_d       = ien_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    salt_d  = {salt_q[119:0], i_data};
                    cnt_d   = 6'd1;
                    ien_d   = 1'b1;
                    state_d = LOAD_KEY;
                end
            end

            LOAD_KEY: begin
                if (i_start) begin
                    if (cnt_q < 6'(SALT_LEN)) begin
                        salt_d = {salt_q[119:0], i_data};
                    end else begin
                        pw_d = pw_shift(pw_q, i_data);
                    end
                    cnt_d = sat_inc(cnt_q);
                    // The edge carrying the last password byte also raises
                    // o_key_valid, so there is no extra cycle of latency.
                    if (cnt_q == 6'(KEY_LEN - 1)) begin
                        cnt_d       = '0;
                        key_valid_d = 1'b1;
                        state_d     = WAIT_KEY;
                    end
                end else begin
                    err_d   = 1'b1;
                    salt_d  = '0;
                    pw_d    = '0;
                    cnt_d   = '0;
                    ien_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            // i_start is ignored here; a byte arriving with the handshake
            // pulse is dropped.
            WAIT_KEY: begin
                if (i_key_done) begin
                    key_valid_d = 1'b0;
                    ien_d       = 1'b0;
                    state_d     = WAIT_MSG;
                end
            end

            WAIT_MSG: begin
                if (i_start) begin
                    msg_d   = {msg_q[119:0], i_data};
                    cnt_d   = 6'd1;
                    ien_d   = 1'b1;
                    state_d = LOAD_MSG;
                end
            end

            LOAD_MSG: begin
                if (i_start) begin
                    msg_d = {msg_q[119:0], i_data};
                    cnt_d = sat_inc(cnt_q);
                    if (cnt_q == 6'(MSG_LEN - 1)) begin
                        cnt_d       = '0;
                        msg_valid_d = 1'b1;
                        state_d     = HOLD_MSG;
                    end
                end else begin
                    err_d   = 1'b1;
                    msg_d   = '0;
                    cnt_d   = '0;
                    ien_d   = 1'b0;
                    state_d = WAIT_MSG;
                end
            end

            HOLD_MSG: begin
                if (i_msg_ack) begin
                    msg_valid_d = 1'b0;
                    ien_d       = 1'b0;
                    state_d     = DONE;
                end
            end

            // Terminal until reset; everything is held.
            DONE: begin
                state_d = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_salt      = salt_q;
    assign o_pw        = pw_q;
    assign o_msg       = msg_q;
    assign o_key_valid = key_valid_q;
    assign o_msg_valid = msg_valid_q;
    assign o_ien       = ien_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_top_input_loader.sv
// ---------------------------------------------------------------------------
// tb_top_input_loader
//
// Directed bench for top_input_loader. Expected salt/password/message words
// are pushed to scoreboard queues when a burst is driven and popped when the
// matching valid flag is seen.
// ---------------------------------------------------------------------------
module tb_top_input_loader;

    localparam int PW = 15;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [7:0]      i_data;
    logic            i_start;
    logic            i_key_done;
    logic            i_msg_ack;
    logic [127:0]    o_salt;
    logic [PW*8-1:0] o_pw;
    logic            o_key_valid;
    logic [127:0]    o_msg;
    logic            o_msg_valid;
    logic            o_ien;
    logic            o_err;

    int checks = 0;
    int errors = 0;

    logic [127:0]    salt_sb[$];
    logic [PW*8-1:0] pw_sb[$];
    logic [127:0]    msg_sb[$];

    top_input_loader #(.PW_LEN(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data     (i_data),
        .i_start    (i_start),
        .i_key_done (i_key_done),
        .i_msg_ack  (i_msg_ack),
        .o_salt     (o_salt),
        .o_pw       (o_pw),
        .o_key_valid(o_key_valid),
        .o_msg      (o_msg),
        .o_msg_valid(o_msg_valid),
        .o_ien      (o_ien),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a full salt+password burst; salt bytes are sb, sb+1, ...
    // and password bytes pb, pb+1, ...
    task automatic load_key(input logic [7:0] sb, input logic [7:0] pb);
        logic [127:0]    es;
        logic [PW*8-1:0] ep;
        for (int i = 0; i < 16; i++) es[127-8*i -: 8] = sb + 8'(i);
        for (int i = 0; i < PW; i++) ep[PW*8-1-8*i -: 8] = pb + 8'(i);
        salt_sb.push_back(es);
        pw_sb.push_back(ep);
        for (int i = 0; i < 16 + PW; i++) begin
            i_start = 1'b1;
            i_data  = (i < 16) ? sb + 8'(i) : pb + 8'(i - 16);
            step();
            if (i == 0) check("ien_rise_key", o_ien, 1);
            if (i == 16 + PW - 2) check("key_valid_early", o_key_valid, 0);
        end
        i_start = 1'b0;
        // Valid must already be up on the edge of the last byte.
        check("key_valid_latency", o_key_valid, 1);
    endtask

    task automatic load_msg(input logic [7:0] mb);
        logic [127:0] em;
        for (int i = 0; i < 16; i++) em[127-8*i -: 8] = mb + 8'(i);
        msg_sb.push_back(em);
        for (int i = 0; i < 16; i++) begin
            i_start = 1'b1;
            i_data  = mb + 8'(i);
            step();
            if (i == 0) check("ien_rise_msg", o_ien, 1);
            if (i == 14) check("msg_valid_early", o_msg_valid, 0);
        end
        i_start = 1'b0;
        check("msg_valid_latency", o_msg_valid, 1);
    endtask

    task automatic expect_key();
        int n = 0;
        while (o_key_valid !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        check("key_valid_seen", o_key_valid, 1);
        if (salt_sb.size() > 0) check("salt", o_salt, salt_sb.pop_front());
        if (pw_sb.size() > 0) check("pw", o_pw, pw_sb.pop_front());
    endtask

    task automatic expect_msg();
        int n = 0;
        while (o_msg_valid !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        check("msg_valid_seen", o_msg_valid, 1);
        if (msg_sb.size() > 0) check("msg", o_msg, msg_sb.pop_front());
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_salt"}, o_salt, 0);
        check({tag, "_pw"}, o_pw, 0);
        check({tag, "_msg"}, o_msg, 0);
        check({tag, "_key_valid"}, o_key_valid, 0);
        check({tag, "_msg_valid"}, o_msg_valid, 0);
        check({tag, "_ien"}, o_ien, 0);
        check({tag, "_err"}, o_err, 0);
    endtask

    localparam logic [127:0]    SALT1 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [PW*8-1:0] PW1   = 120'h101112131415161718191A1B1C1D1E;
    localparam logic [127:0]    MSG1  = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;

    initial begin
        rst_n      = 1'b0;
        i_data     = 8'h00;
        i_start    = 1'b0;
        i_key_done = 1'b0;
        i_msg_ack  = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Full key load 00..0F / 10..1E
        load_key(8'h00, 8'h10);
        check("salt_literal", o_salt, SALT1);
        check("pw_literal", o_pw, PW1);
        expect_key();
        step();
        step();
        check("wait_key_valid_hold", o_key_valid, 1);
        check("wait_key_ien_hold", o_ien, 1);

        // Stray i_start and i_msg_ack in WAIT_KEY
        for (int i = 0; i < 3; i++) begin
            i_start = 1'b1;
            i_data  = 8'hFF;
            step();
        end
        i_start   = 1'b0;
        i_msg_ack = 1'b1;
        step();
        i_msg_ack = 1'b0;
        check("stray_wk_salt", o_salt, SALT1);
        check("stray_wk_pw", o_pw, PW1);
        check("stray_wk_msg", o_msg, 0);
        check("stray_wk_key_valid", o_key_valid, 1);
        check("stray_wk_err", o_err, 0);

        // Key handshake
        i_key_done = 1'b1;
        step();
        i_key_done = 1'b0;
        check("key_done_valid", o_key_valid, 0);
        check("key_done_ien", o_ien, 0);
        check("key_done_salt_kept", o_salt, SALT1);

        // Stray i_key_done in WAIT_MSG
        i_key_done = 1'b1;
        step();
        i_key_done = 1'b0;
        check("stray_wm_ien", o_ien, 0);
        check("stray_wm_msg", o_msg, 0);
        check("stray_wm_pw", o_pw, PW1);

        // Message load A0..AF
        load_msg(8'hA0);
        check("msg_literal", o_msg, MSG1);
        expect_msg();
        i_start = 1'b1;
        i_data  = 8'h55;
        step();
        i_start = 1'b0;
        check("stray_hold_msg", o_msg, MSG1);
        i_msg_ack = 1'b1;
        step();
        i_msg_ack = 1'b0;
        check("ack_msg_valid", o_msg_valid, 0);
        check("ack_ien", o_ien, 0);
        check("ack_salt_kept", o_salt, SALT1);
        check("ack_msg_kept", o_msg, MSG1);

        // DONE ignores everything
        i_start    = 1'b1;
        i_data     = 8'h33;
        i_key_done = 1'b1;
        step();
        i_key_done = 1'b0;
        i_msg_ack  = 1'b1;
        step();
        i_msg_ack  = 1'b0;
        step();
        i_start    = 1'b0;
        check("done_ien", o_ien, 0);
        check("done_msg", o_msg, MSG1);
        check("done_salt", o_salt, SALT1);
        check("done_err", o_err, 0);

        // Truncated salt after 9 bytes
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            i_start = 1'b1;
            i_data  = 8'hC0 + 8'(i);
            step();
        end
        i_start = 1'b0;
        step();
        check("trunc_err", o_err, 1);
        check("trunc_ien", o_ien, 0);
        check("trunc_salt", o_salt, 0);
        step();
        check("trunc_err_pulse", o_err, 0);

        // Reload after truncation, then handshake with a colliding byte
        load_key(8'h20, 8'h40);
        expect_key();
        i_key_done = 1'b1;
        i_start    = 1'b1;
        i_data     = 8'h77;
        step();
        i_key_done = 1'b0;
        i_start    = 1'b0;
        check("collide_key_valid", o_key_valid, 0);
        check("collide_ien", o_ien, 0);
        step();
        check("collide_msg", o_msg, 0);
        check("collide_ien_idle", o_ien, 0);

        // Truncated message after 5 bytes, then a full message
        for (int i = 0; i < 5; i++) begin
            i_start = 1'b1;
            i_data  = 8'hE0 + 8'(i);
            step();
        end
        i_start = 1'b0;
        step();
        check("trunc_msg_err", o_err, 1);
        check("trunc_msg_msg", o_msg, 0);
        check("trunc_msg_ien", o_ien, 0);
        load_msg(8'hB0);
        expect_msg();

        // Reset mid LOAD_MSG after 7 bytes
        i_msg_ack = 1'b1;
        step();
        i_msg_ack = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        load_key(8'h60, 8'h80);
        expect_key();
        i_key_done = 1'b1;
        step();
        i_key_done = 1'b0;
        for (int i = 0; i < 7; i++) begin
            i_start = 1'b1;
            i_data  = 8'hD0 + 8'(i);
            step();
        end
        rst_n = 1'b0;
        step();
        check_all_zero("rst_mid");
        rst_n   = 1'b1;
        i_start = 1'b0;
        step();
        check("rst_mid_no_err", o_err, 0);
        i_start = 1'b1;
        i_data  = 8'h99;
        step();
        i_start = 1'b0;
        check("rst_new_burst_ien", o_ien, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
